// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU in Execute: one quotient bit per cycle,
// stalls the pipe while busy and pulses ready with {HI=remainder, LO=quotient}.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, DONE} state_t;

  state_t           state, nextState;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quot, divisor;
  logic             qSign, rSign;

  logic             startOk, lastStep;
  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] stepRem, stepQuot, fixRem, fixQuot;

  always_comb begin
    startOk  = (state == IDLE) && start_i && !annul_i;
    lastStep = (count == CW'(WIDTH - 1));
    absA     = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    absB     = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
    // Borrow out of the (WIDTH+1)-bit trial subtract means the divisor did not fit.
    trial    = {rem, quot[WIDTH-1]} - {1'b0, divisor};
    stepRem  = trial[WIDTH] ? {rem[WIDTH-2:0], quot[WIDTH-1]} : trial[WIDTH-1:0];
    stepQuot = {quot[WIDTH-2:0], ~trial[WIDTH]};
    fixQuot  = qSign ? -stepQuot : stepQuot;
    fixRem   = rSign ? -stepRem : stepRem;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    busy_o    = 1'b0;
    ready_o   = 1'b0;
    case (state)
      IDLE: begin
        busy_o = startOk;
        if (startOk) nextState = (b_i == '0) ? DIVZERO : ON;
      end
      DIVZERO: begin
        busy_o    = 1'b1;
        nextState = annul_i ? IDLE : DONE;
      end
      ON: begin
        busy_o = 1'b1;
        if (annul_i)       nextState = IDLE;
        else if (lastStep) nextState = DONE;
      end
      DONE: begin
        ready_o   = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      rem      <= '0;
      quot     <= '0;
      divisor  <= '0;
      qSign    <= 1'b0;
      rSign    <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (startOk) begin
            count <= '0;
            if (b_i == '0) begin
              rem  <= a_i;
              quot <= '1;
            end else begin
              rem     <= '0;
              quot    <= absA;
              divisor <= absB;
              qSign   <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
              rSign   <= signed_i & a_i[WIDTH-1];
            end
          end
        end
        DIVZERO: begin
          if (!annul_i) result_o <= {rem, quot};
        end
        ON: begin
          if (!annul_i) begin
            rem   <= stepRem;
            quot  <= stepQuot;
            count <= count + 1'b1;
            if (lastStep) result_o <= {fixRem, fixQuot};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, busy/ready timing, signed fix-up,
// divide-by-zero, annul and mid-operation reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, sgn, annul;
  logic [31:0] a, b;
  logic        busy, ready;
  logic [63:0] result;

  int passCnt = 0;
  int totalCnt = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .signed_i(sgn),
    .a_i(a), .b_i(b), .annul_i(annul),
    .busy_o(busy), .ready_o(ready), .result_o(result)
  );

  always #5 clk = ~clk;

  // Issues one request, scrambles operands after acceptance, waits (bounded) for ready.
  task automatic doDiv(input logic s, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int busyErr, output logic busyStart,
                       output logic busyDone, output logic [63:0] res);
    @(negedge clk);
    start = 1'b1; sgn = s; a = x; b = y;
    #1 busyStart = busy;
    @(posedge clk);
    #1 start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0; sgn = ~s;
    lat = 1; busyErr = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready) break;
      if (!busy) busyErr++;
      @(posedge clk);
      lat++;
    end
    res = result;
    busyDone = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sgn = 1'b0; annul = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    totalCnt++;
    if ({busy, ready, result} !== 66'd0) $display("FAIL reset_state: got busy=%b ready=%b result=%h, want 0/0/0", busy, ready, result);
    else passCnt++;
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat, be; logic bs, bd; logic [63:0] r;
    doDiv(1'b0, 32'd100, 32'd7, lat, be, bs, bd, r);
    totalCnt++;
    if (lat !== 33) $display("FAIL u100_7_latency: got %0d, want 33", lat); else passCnt++;
    totalCnt++;
    if (r !== {32'h2, 32'hE}) $display("FAIL u100_7_result: got %h, want %h", r, {32'h2, 32'hE}); else passCnt++;
    totalCnt++;
    if (bs !== 1'b1 || be !== 0 || bd !== 1'b0)
      $display("FAIL u100_7_busy: got start=%b gaps=%0d done=%b, want 1/0/0", bs, be, bd);
    else passCnt++;
    @(negedge clk);
    totalCnt++;
    if (ready !== 1'b0 || result !== {32'h2, 32'hE}) $display("FAIL u100_7_hold: got ready=%b result=%h, want 0/%h", ready, result, {32'h2, 32'hE});
    else passCnt++;
    doDiv(1'b0, 32'hFFFFFFF9, 32'h2, lat, be, bs, bd, r);
    totalCnt++;
    if (r !== {32'h1, 32'h7FFFFFFC}) $display("FAIL u_fff9_2: got %h, want %h", r, {32'h1, 32'h7FFFFFFC}); else passCnt++;
    doDiv(1'b0, 32'hFFFFFFFF, 32'h1, lat, be, bs, bd, r);
    totalCnt++;
    if (r !== {32'h0, 32'hFFFFFFFF}) $display("FAIL u_max_1: got %h, want %h", r, {32'h0, 32'hFFFFFFFF}); else passCnt++;
  endtask

  task automatic test_signed();
    int lat, be; logic bs, bd; logic [63:0] r;
    doDiv(1'b1, 32'hFFFFFFF9, 32'h2, lat, be, bs, bd, r);
    totalCnt++;
    if (r !== {32'hFFFFFFFF, 32'hFFFFFFFD}) $display("FAIL s_m7_2: got %h, want %h", r, {32'hFFFFFFFF, 32'hFFFFFFFD}); else passCnt++;
    doDiv(1'b1, 32'h7, 32'hFFFFFFFE, lat, be, bs, bd, r);
    totalCnt++;
    if (r !== {32'h1, 32'hFFFFFFFD}) $display("FAIL s_7_m2: got %h, want %h", r, {32'h1, 32'hFFFFFFFD}); else passCnt++;
    doDiv(1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, lat, be, bs, bd, r);
    totalCnt++;
    if (r !== {32'hFFFFFFFE, 32'h2}) $display("FAIL s_m8_m3: got %h, want %h", r, {32'hFFFFFFFE, 32'h2}); else passCnt++;
    doDiv(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, be, bs, bd, r);
    totalCnt++;
    if (r !== {32'h0, 32'h80000000}) $display("FAIL s_overflow: got %h, want %h", r, {32'h0, 32'h80000000}); else passCnt++;
  endtask

  task automatic test_divzero();
    int lat, be; logic bs, bd; logic [63:0] r;
    doDiv(1'b0, 32'h1234, 32'h0, lat, be, bs, bd, r);
    totalCnt++;
    if (lat !== 2) $display("FAIL div0_latency: got %0d, want 2", lat); else passCnt++;
    totalCnt++;
    if (r !== {32'h1234, 32'hFFFFFFFF}) $display("FAIL div0_result: got %h, want %h", r, {32'h1234, 32'hFFFFFFFF}); else passCnt++;
    totalCnt++;
    if (bs !== 1'b1 || be !== 0 || bd !== 1'b0) $display("FAIL div0_busy: got start=%b gaps=%0d done=%b, want 1/0/0", bs, be, bd); else passCnt++;
  endtask

  task automatic test_annul();
    int lat, be, rdySeen; logic bs, bd; logic [63:0] r, prev;
    prev = result;
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = 32'd500; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 annul = 1'b1;
    @(posedge clk);
    #1 annul = 1'b0;
    @(negedge clk);
    totalCnt++;
    if (busy !== 1'b0 || ready !== 1'b0 || result !== prev)
      $display("FAIL annul_idle: got busy=%b ready=%b result=%h, want 0/0/%h", busy, ready, result, prev);
    else passCnt++;
    rdySeen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ready) rdySeen++;
    end
    totalCnt++;
    if (rdySeen !== 0) $display("FAIL annul_no_ready: got %0d pulses, want 0", rdySeen); else passCnt++;
    doDiv(1'b0, 32'd1000, 32'd10, lat, be, bs, bd, r);
    totalCnt++;
    if (lat !== 33 || r !== {32'h0, 32'h64}) $display("FAIL annul_restart: got lat=%0d result=%h, want 33/%h", lat, r, {32'h0, 32'h64});
    else passCnt++;
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = 32'd77; b = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    totalCnt++;
    if (ready !== 1'b0 || busy !== 1'b0 || result !== 64'd0)
      $display("FAIL reset_mid: got ready=%b busy=%b result=%h, want 0/0/0", ready, busy, result);
    else passCnt++;
    start = 1'b1; annul = 1'b1; a = 32'd9; b = 32'd3;
    #1;
    totalCnt++;
    if (busy !== 1'b0) $display("FAIL annul_start_busy: got %b, want 0", busy); else passCnt++;
    @(posedge clk);
    #1 start = 1'b0; annul = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy || ready) bad++;
    end
    totalCnt++;
    if (bad !== 0) $display("FAIL annul_start_ignored: got %0d active cycles, want 0", bad); else passCnt++;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_divzero();
    test_annul();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative divider for DIV/DIVU in the Execute stage of the five-stage MIPS pipeline.
- Consumes Execute-stage operands and the decoded divide request.
- Drives a stall request to the hazard unit while busy.
- Delivers {HI=remainder, LO=quotient}, which travels down the pipe with MulDiv/WriteHiLo to the HI/LO write in Writeback.
- Radix-2 restoring algorithm: one quotient bit per cycle.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start_i  input  1  divide request from Execute (decoded DIV/DIVU, not stalled-out)
signed_i  input  1  1 = DIV (signed), 0 = DIVU
a_i  input  WIDTH  dividend (rs)
b_i  input  WIDTH  divisor (rt)
annul_i  input  1  flushE / exception cancel; abandons current operation
busy_o  output  1  stall request to hazard unit (drives stallF/D/E)
ready_o  output  1  one-cycle pulse: result_o valid
result_o  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}

Behaviour:
- Reset: state=IDLE, counter=0, ready_o=0, result_o=0, internal regs=0. Reset mid-operation aborts immediately; no ready_o pulse.
- States: IDLE, DIVZERO, ON, DONE.
- IDLE → DIVZERO: start_i=1, annul_i=0, b_i=0.
- IDLE → ON: start_i=1, annul_i=0, b_i≠0. Latch |a|, |b| (magnitudes if signed_i, else raw), sign of quotient (a[msb]^b[msb]), sign of remainder (a[msb]), signed_i. Clear partial remainder; counter=0.
- ON: each cycle shift {rem,quot} left 1; trial subtract divisor; set quotient bit if non-negative and keep difference. Counter increments. After WIDTH ON cycles → DONE.
- DIVZERO → DONE after one cycle. Result: remainder=a_i as latched, quotient=all ones.
- DONE:
  - ready_o=1 for exactly this cycle; result_o updated on entry to DONE.
  - Signed fix-up: negate quotient if quotient sign=1; negate remainder if remainder sign=1 (remainder takes dividend's sign).
  - Next state IDLE unconditionally; a start_i in DONE is ignored.
- result_o holds its value after DONE until the next DONE or reset.
- busy_o = (state==IDLE & start_i & ~annul_i) | state==ON | state==DIVZERO. Combinational, so the stall asserts in the same cycle the DIV reaches Execute. Deasserted in DONE, so the instruction advances exactly as ready_o pulses.
- annul_i=1 in ON or DIVZERO: next state IDLE; no ready_o; result_o unchanged. annul_i with start_i in IDLE: request ignored.
- Overflow 0x80000000 / 0xFFFFFFFF signed: quotient=0x80000000, remainder=0 (natural two's-complement wrap); no trap.
- Latency: start accepted at edge t; ON occupies cycles t+1..t+WIDTH; ready_o at cycle t+WIDTH+1 (33 cycles for WIDTH=32). Divide-by-zero: ready_o at t+2.
- Operands are sampled only at start; a_i/b_i changes during ON have no effect.
- Counter width $clog2(WIDTH)+1; no wrap inside one operation.

Test Plan:
- Unsigned 100 / 7, start at cycle 0 → busy_o high cycles 0..32; ready_o at cycle 33; result_o = {32'h2, 32'hE}.
- Signed -7 / 2 (0xFFFFFFF9, 0x2, signed_i=1) → result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}. Same operands unsigned → {32'h1, 32'h7FFFFFFC}.
- Signed 0x80000000 / 0xFFFFFFFF → {32'h0, 32'h80000000}. Unsigned 0xFFFFFFFF / 1 → {32'h0, 32'hFFFFFFFF}.
- Divide by zero, a=0x1234 → ready_o 2 cycles after start; result_o = {32'h1234, 32'hFFFFFFFF}; busy_o low in DONE.
- annul_i at ON cycle 10 → IDLE next cycle; no ready_o; result_o keeps previous value; new start next cycle completes normally.
- rst at ON cycle 5 → next cycle ready_o=0, busy_o=0, result_o=0; start_i asserted with annul_i in IDLE → busy_o=0, no operation.
